// File: rtl/filter_tap_select.sv
// Output stage of the image filter chain: selects one of NUM_TAPS synchronised pixel
// streams, with mode/threshold/inversion changes applied only on frame boundaries.
// Optional edge statistics are enabled by defining FILTER_TAP_STATS_EN.
module filter_tap_select #(
  parameter int WIDTH       = 8,
  parameter int NUM_TAPS    = 4,
  parameter int SEL_W       = $clog2(NUM_TAPS),
  parameter int DEF_MODE    = NUM_TAPS - 1,
  parameter int DEF_TH_HIGH = 230,
  parameter int DEF_TH_LOW  = 180,
  parameter int EDGE_LEVEL  = 255,
  parameter int CNT_W       = 17
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_TAPS-1:0]       i_vsync,
  input  logic [NUM_TAPS-1:0]       i_hsync,
  input  logic [NUM_TAPS-1:0]       i_de,
  input  logic [NUM_TAPS*WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0]          i_mode,
  input  logic [WIDTH-1:0]          i_th_high,
  input  logic [WIDTH-1:0]          i_th_low,
  input  logic                      i_invert,
  output logic                      o_vsync,
  output logic                      o_hsync,
  output logic                      o_de,
  output logic [WIDTH-1:0]          o_data,
  output logic [WIDTH-1:0]          o_th_high,
  output logic [WIDTH-1:0]          o_th_low,
  output logic [SEL_W-1:0]          o_mode_active,
  output logic                      o_switching,
  output logic [15:0]               o_frame_cnt,
  output logic [CNT_W-1:0]          o_edge_cnt,
  output logic                      o_edge_valid
);

  typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

  localparam logic [SEL_W-1:0] DEF_M  = SEL_W'(DEF_MODE);
  localparam logic [SEL_W:0]   NT     = (SEL_W + 1)'(NUM_TAPS);
  localparam logic [WIDTH-1:0] DEF_TH = WIDTH'(DEF_TH_HIGH);
  localparam logic [WIDTH-1:0] DEF_TL = WIDTH'(DEF_TH_LOW);

  state_t           state_q, state_nxt;
  logic [SEL_W-1:0] mode_nxt;
  logic             vs_prev;
  logic             started_q, started_nxt;
  logic             inv_q, inv_eff;
  logic             fb;
  logic             mode_ok;
  logic             sel_vs, sel_de;
  logic [WIDTH-1:0] sel_data;
  logic             nxt_vs, nxt_hs;
  logic             de_nxt;
  logic [WIDTH-1:0] data_nxt;

  // Current tap: drives frame-boundary detection and pixel data
  always_comb begin
    sel_vs   = 1'b0;
    sel_de   = 1'b0;
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_TAPS; k++) begin
      if (o_mode_active == SEL_W'(k)) begin
        sel_vs   = i_vsync[k];
        sel_de   = i_de[k];
        sel_data = i_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign fb      = sel_vs & ~vs_prev;
  assign mode_ok = ({1'b0, i_mode} < NT) && (i_mode != o_mode_active);

  always_comb begin
    state_nxt = state_q;
    mode_nxt  = o_mode_active;
    if (state_q == ST_RUN) begin
      if (fb && mode_ok) begin
        mode_nxt  = i_mode;
        state_nxt = ST_WAIT;
      end
    end else if (fb) begin
      state_nxt = ST_RUN;
    end
  end

  // Syncs and the vsync history follow the tap selected for the next cycle, so the
  // new tap's first rising vsync after a switch is seen against its own history.
  always_comb begin
    nxt_vs = 1'b0;
    nxt_hs = 1'b0;
    for (int unsigned k = 0; k < NUM_TAPS; k++) begin
      if (mode_nxt == SEL_W'(k)) begin
        nxt_vs = i_vsync[k];
        nxt_hs = i_hsync[k];
      end
    end
  end

  // Pixels pass only in steady RUN, and only once a boundary has been seen since reset;
  // the boundary cycle's pixel already belongs to the new frame and its inversion.
  always_comb begin
    started_nxt = started_q | fb;
    inv_eff     = fb ? i_invert : inv_q;
    de_nxt      = started_nxt && (state_q == ST_RUN) && (state_nxt == ST_RUN) && sel_de;
    data_nxt    = de_nxt ? (inv_eff ? ~sel_data : sel_data) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= ST_RUN;
      o_mode_active <= DEF_M;
      vs_prev       <= i_vsync[DEF_MODE];
      started_q     <= 1'b0;
      inv_q         <= 1'b0;
      o_th_high     <= DEF_TH;
      o_th_low      <= DEF_TL;
      o_frame_cnt   <= '0;
      o_vsync       <= 1'b0;
      o_hsync       <= 1'b0;
      o_de          <= 1'b0;
      o_data        <= '0;
      o_switching   <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      o_mode_active <= mode_nxt;
      vs_prev       <= nxt_vs;
      started_q     <= started_nxt;
      if (fb) begin
        inv_q       <= i_invert;
        o_th_high   <= i_th_high;
        o_th_low    <= (i_th_low > i_th_high) ? i_th_high : i_th_low;
        o_frame_cnt <= o_frame_cnt + 16'd1;
      end
      o_vsync     <= nxt_vs;
      o_hsync     <= nxt_hs;
      o_de        <= de_nxt;
      o_data      <= data_nxt;
      o_switching <= (state_nxt == ST_WAIT);
    end
  end

`ifdef FILTER_TAP_STATS_EN
  localparam logic [WIDTH-1:0] EDGE_L = WIDTH'(EDGE_LEVEL);

  logic [CNT_W-1:0] acc_q;
  logic             is_edge;

  assign is_edge = de_nxt && (data_nxt >= EDGE_L);

  // The first boundary after reset closes a frame that was never fully observed,
  // so it only restarts the accumulator.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q        <= '0;
      o_edge_cnt   <= '0;
      o_edge_valid <= 1'b0;
    end else begin
      o_edge_valid <= 1'b0;
      if (fb) begin
        acc_q <= CNT_W'(is_edge);
        if (started_q) begin
          o_edge_cnt   <= acc_q;
          o_edge_valid <= 1'b1;
        end
      end else if (is_edge && (acc_q != '1)) begin
        acc_q <= acc_q + 1'b1;
      end
    end
  end
`else
  assign o_edge_cnt   = '0;
  assign o_edge_valid = 1'b0;
`endif

endmodule
